// File: rtl/hermes_output_arbiter.sv
// Round-robin, packet-length-aware arbiter for one Hermes router output port.
// Optional stall watchdog is built only when HERMES_ARB_TIMEOUT_EN is defined.
module hermes_output_arbiter #(
    parameter int NPORT     = 5,
    parameter int FLIT_SIZE = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NPORT-1:0]         req_i,
    input  logic [FLIT_SIZE-1:0]     data_i,
    input  logic                     flit_valid_i,
    input  logic                     flit_ready_i,
    output logic [NPORT-1:0]         grant_o,
    output logic [$clog2(NPORT)-1:0] sel_o,
    output logic                     busy_o,
    output logic                     pkt_done_o,
    output logic                     timeout_o
);
    localparam int SEL_W = $clog2(NPORT);
    localparam logic [SEL_W-1:0] LAST_RESET = SEL_W'(NPORT - 1);

    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

    state_t               state, state_next;
    logic [NPORT-1:0]     grant_next;
    logic [SEL_W-1:0]     sel_next;
    logic [SEL_W-1:0]     last, last_next;
    logic [SEL_W-1:0]     winner, idx;
    logic                 found;
    logic [FLIT_SIZE-1:0] count, count_next;
    logic                 busy_next, pkt_done_next, timeout_next;
    logic                 xfer;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("hermes_output_arbiter: TIMEOUT must be at least 1");
    end

`ifdef HERMES_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall, stall_next;
`endif

    assign xfer = flit_valid_i & flit_ready_i;

    // First requester found scanning upward from the port after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = last;
        idx    = last;
        for (int k = 1; k <= NPORT; k++) begin
            idx = SEL_W'((int'(last) + k) % NPORT);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant_o;
        sel_next      = sel_o;
        last_next     = last;
        count_next    = count;
        pkt_done_next = 1'b0;
        timeout_next  = 1'b0;
`ifdef HERMES_ARB_TIMEOUT_EN
        stall_next    = '0;
`endif
        case (state)
            IDLE: begin
                grant_next = '0;
                if (found) begin
                    grant_next = NPORT'(1) << winner;
                    sel_next   = winner;
                    last_next  = winner;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (xfer) state_next = SIZE;
            end
            SIZE: begin
                if (xfer) begin
                    count_next = data_i;
                    if (data_i == '0) begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        pkt_done_next = 1'b1;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    count_next = count - FLIT_SIZE'(1);
                    if (count == FLIT_SIZE'(1)) begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        pkt_done_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef HERMES_ARB_TIMEOUT_EN
        // A transfer always wins over the watchdog in the same cycle.
        if (state != IDLE && !xfer) begin
            if (stall == STALL_W'(TIMEOUT - 1)) begin
                state_next   = IDLE;
                grant_next   = '0;
                timeout_next = 1'b1;
            end else begin
                stall_next = stall + STALL_W'(1);
            end
        end
`endif
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant_o    <= '0;
            sel_o      <= '0;
            last       <= LAST_RESET;
            count      <= '0;
            busy_o     <= 1'b0;
            pkt_done_o <= 1'b0;
            timeout_o  <= 1'b0;
`ifdef HERMES_ARB_TIMEOUT_EN
            stall      <= '0;
`endif
        end else begin
            state      <= state_next;
            grant_o    <= grant_next;
            sel_o      <= sel_next;
            last       <= last_next;
            count      <= count_next;
            busy_o     <= busy_next;
            pkt_done_o <= pkt_done_next;
            timeout_o  <= timeout_next;
`ifdef HERMES_ARB_TIMEOUT_EN
            stall      <= stall_next;
`endif
        end
    end

endmodule

// File: tb/tb_hermes_output_arbiter.sv
// Self-checking bench for hermes_output_arbiter: packet-level reference model plus directed and random scenarios.
// Timeout scenarios adapt to whether HERMES_ARB_TIMEOUT_EN is defined.
module tb_hermes_output_arbiter;
    localparam int NPORT     = 5;
    localparam int FLIT_SIZE = 32;
    localparam int TIMEOUT   = 16;
    localparam int SEL_W     = $clog2(NPORT);
    localparam int VW        = NPORT + SEL_W + 3;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NPORT-1:0]     req_i = '0;
    logic [FLIT_SIZE-1:0] data_i = '0;
    logic                 flit_valid_i = 1'b0;
    logic                 flit_ready_i = 1'b0;
    logic [NPORT-1:0]     grant_o;
    logic [SEL_W-1:0]     sel_o;
    logic                 busy_o;
    logic                 pkt_done_o;
    logic                 timeout_o;

    int asserts = 0;
    int fails   = 0;

    // Reference model: owner port, flits seen in the current packet, packet length once known.
    int               m_owner = -1;
    int               m_last  = NPORT - 1;
    logic [SEL_W-1:0] m_sel   = '0;
    longint           m_seen  = 0;
    longint           m_total = 0;
    int               m_stall = 0;
    logic             m_done  = 1'b0;
    logic             m_tmo   = 1'b0;

    hermes_output_arbiter #(
        .NPORT(NPORT), .FLIT_SIZE(FLIT_SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
        .flit_valid_i(flit_valid_i), .flit_ready_i(flit_ready_i),
        .grant_o(grant_o), .sel_o(sel_o), .busy_o(busy_o),
        .pkt_done_o(pkt_done_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_step();
        int               base;
        int               p;
        logic [NPORT-1:0] sh;
        if (rst_i) begin
            m_owner = -1; m_last = NPORT - 1; m_sel = '0;
            m_seen = 0; m_total = 0; m_stall = 0; m_done = 1'b0; m_tmo = 1'b0;
        end else begin
            m_done = 1'b0;
            m_tmo  = 1'b0;
            if (m_owner < 0) begin
                base = m_last;
                for (int k = 1; k <= NPORT; k++) begin
                    p  = (base + k) % NPORT;
                    sh = req_i >> p;
                    if (m_owner < 0 && sh[0]) begin
                        m_owner = p; m_last = p; m_sel = SEL_W'(p);
                        m_seen = 0; m_stall = 0;
                    end
                end
            end else if (flit_valid_i && flit_ready_i) begin
                m_seen++;
                m_stall = 0;
                if (m_seen == 2) m_total = 2 + longint'(data_i);
                if (m_seen >= 2 && m_seen == m_total) begin
                    m_owner = -1; m_done = 1'b1; m_seen = 0;
                end
            end else begin
`ifdef HERMES_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_owner = -1; m_tmo = 1'b1; m_stall = 0; m_seen = 0;
                end
`endif
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NPORT-1:0] g;
        g = '0;
        if (m_owner >= 0) g = NPORT'(1) << m_owner;
        return {g, m_sel, (m_owner >= 0), m_done, m_tmo};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {grant_o, sel_o, busy_o, pkt_done_o, timeout_o};
    endfunction

    task automatic step(input logic r, input logic [NPORT-1:0] rq, input logic v,
                        input logic rd, input logic [FLIT_SIZE-1:0] d);
        rst_i = r; req_i = rq; flit_valid_i = v; flit_ready_i = rd; data_i = d;
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, NPORT'($urandom), 1'($urandom), 1'($urandom), $urandom);
            asserts++;
            if (act_vec() !== VW'(0)) begin
                fails++;
                $display("[TB] FAIL reset_values: got %b, expected %b", act_vec(), VW'(0));
            end
        end
    endtask

    task automatic test_single_packet();
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, (i == 0) ? NPORT'(1) : '0, (i >= 1 && i <= 5), 1'b1,
                 (i == 2) ? FLIT_SIZE'(3) : $urandom);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL single_packet cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
            if (i == 0) begin
                asserts++;
                if (grant_o !== 5'b00001) begin
                    fails++;
                    $display("[TB] FAIL single_grant_latency: got %b, expected 00001", grant_o);
                end
            end
            if (i == 5) begin
                asserts++;
                if ({pkt_done_o, grant_o} !== 6'b100000) begin
                    fails++;
                    $display("[TB] FAIL single_done: got done=%b grant=%b, expected done=1 grant=00000", pkt_done_o, grant_o);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NPORT-1:0] seen_grants[$];
        logic [NPORT-1:0] prev;
        logic [NPORT-1:0] want;
        step(1'b1, '0, 1'b0, 1'b0, '0);
        prev = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 5'b10101, 1'b1, 1'b1, FLIT_SIZE'(1));
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL round_robin cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
            if (grant_o != '0 && prev == '0) seen_grants.push_back(grant_o);
            prev = grant_o;
        end
        asserts++;
        if (seen_grants.size() != 4) begin
            fails++;
            $display("[TB] FAIL rr_grant_count: got %0d, expected 4", seen_grants.size());
        end
        for (int n = 0; n < seen_grants.size() && n < 4; n++) begin
            want = (n == 1) ? 5'b00100 : (n == 2) ? 5'b10000 : 5'b00001;
            asserts++;
            if (seen_grants[n] !== want) begin
                fails++;
                $display("[TB] FAIL rr_order %0d: got %b, expected %b", n, seen_grants[n], want);
            end
        end
    endtask

    task automatic test_zero_size();
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i == 0) ? 5'b00100 : '0, (i == 1 || i == 2), 1'b1,
                 (i == 2) ? '0 : $urandom);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL zero_size cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
            if (i == 2) begin
                asserts++;
                if ({pkt_done_o, busy_o, grant_o} !== 7'b1000000) begin
                    fails++;
                    $display("[TB] FAIL zero_size_release: got done=%b busy=%b grant=%b, expected 1 0 00000", pkt_done_o, busy_o, grant_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, (i == 0) ? 5'b01000 : '0, 1'b1, !(i >= 5 && i < 12),
                 (i == 2) ? FLIT_SIZE'(4) : $urandom);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL stall cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
            if (i >= 5 && i <= 12) begin
                asserts++;
                if ({grant_o, pkt_done_o} !== 6'b010000) begin
                    fails++;
                    $display("[TB] FAIL stall_hold cyc %0d: got grant=%b done=%b, expected 01000 0", i, grant_o, pkt_done_o);
                end
            end
            if (i == 13) begin
                asserts++;
                if (pkt_done_o !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL stall_done: got %b, expected 1", pkt_done_o);
                end
            end
        end
    endtask

    task automatic test_owner_drop();
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i == 0) ? 5'b00010 : 5'b10000, (i >= 1), 1'b1,
                 (i == 2) ? FLIT_SIZE'(2) : $urandom);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL owner_drop cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
            if (i <= 3) begin
                asserts++;
                if (grant_o !== 5'b00010) begin
                    fails++;
                    $display("[TB] FAIL owner_drop_hold cyc %0d: got %b, expected 00010", i, grant_o);
                end
            end
            if (i == 5) begin
                asserts++;
                if (grant_o !== 5'b10000) begin
                    fails++;
                    $display("[TB] FAIL owner_drop_next: got %b, expected 10000", grant_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) begin
            step((i == 4), (i == 0) ? 5'b01000 : 5'b11111, 1'b1, 1'b1,
                 (i == 2) ? FLIT_SIZE'(5) : $urandom);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL reset_mid cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
            if (i == 4) begin
                asserts++;
                if (act_vec() !== VW'(0)) begin
                    fails++;
                    $display("[TB] FAIL reset_mid_values: got %b, expected %b", act_vec(), VW'(0));
                end
            end
            if (i == 5) begin
                asserts++;
                if (grant_o !== 5'b00001) begin
                    fails++;
                    $display("[TB] FAIL reset_mid_priority: got %b, expected 00001", grant_o);
                end
            end
        end
    endtask

    task automatic test_max_size();
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i == 0) ? 5'b00001 : '0, 1'b1, 1'b1,
                 (i == 2) ? '1 : $urandom);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL max_size cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
        end
        asserts++;
        if ({busy_o, pkt_done_o} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL max_size_hold: got busy=%b done=%b, expected 1 0", busy_o, pkt_done_o);
        end
    endtask

    task automatic test_timeout();
        int tmo_pulses;
        int want;
`ifdef HERMES_ARB_TIMEOUT_EN
        want = 1;
`else
        want = 0;
`endif
        tmo_pulses = 0;
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 23; i++) begin
            step(1'b0, (i == 0) ? 5'b00100 : 5'b11111, 1'b0, 1'($urandom), $urandom);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL timeout cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
            if (timeout_o === 1'b1) tmo_pulses++;
        end
        asserts++;
        if (tmo_pulses != want) begin
            fails++;
            $display("[TB] FAIL timeout_pulses: got %0d, expected %0d", tmo_pulses, want);
        end
    endtask

    task automatic test_random();
        logic [FLIT_SIZE-1:0] d;
        step(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 1500; i++) begin
            d = (m_owner >= 0 && m_seen == 1) ? FLIT_SIZE'($urandom_range(0, 4)) : $urandom;
            step(($urandom_range(0, 199) == 0), NPORT'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), d);
            asserts++;
            if (act_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL random cyc %0d: got %b, expected %b", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        $display("[TB] hermes_output_arbiter bench start");
        test_reset();
        test_single_packet();
        test_round_robin();
        test_zero_size();
        test_stall();
        test_owner_drop();
        test_reset_mid_packet();
        test_max_size();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
